// File: rtl/apb_pkg.sv
// Shared types and constants for the multi-slave APB master.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        ERR    = 2'd3
    } state_e;

    localparam logic [1:0] TRF_WR = 2'b01;
    localparam logic [1:0] TRF_RD = 2'b10;

    // Slave-select field width; a 2-slave bus still needs one bit.
    function automatic int sel_width(input int num_slv);
        return (num_slv > 2) ? $clog2(num_slv) : 1;
    endfunction

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational slave decode: top address bits -> one-hot select plus a
// decode error when the field names a slave that does not exist.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int NUM_SLV = 4,
    parameter int SEL_W   = 2
) (
    input  logic [SEL_W-1:0]   addr_hi_i,
    output logic [NUM_SLV-1:0] sel_o,
    output logic [SEL_W-1:0]   idx_o,
    output logic               dec_err_o
);

    assign idx_o     = addr_hi_i;
    assign dec_err_o = ({1'b0, addr_hi_i} >= (SEL_W + 1)'(NUM_SLV));

    always_comb begin
        sel_o = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            sel_o[i] = !dec_err_o && (addr_hi_i == SEL_W'(i));
        end
    end

endmodule

// File: rtl/apb_master_mc.sv
// Multi-slave APB master with registered bus outputs and one-pulse responses.
// Define APB_TIMEOUT_EN to abort ACCESS phases that wait TIMEOUT cycles.
module apb_master_mc
    import apb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                      pclk,
    input  logic                      prst,
    input  logic                      trf_valid,
    output logic                      trf_ready,
    input  logic [1:0]                trf_enc,
    input  logic [ADDR_W-1:0]         trf_addr,
    input  logic [DATA_W-1:0]         trf_wdata,
    input  logic [DATA_W/8-1:0]       trf_strb,
    output logic                      rsp_valid,
    output logic                      rsp_write,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [NUM_SLV-1:0]        psel,
    output logic                      penable,
    output logic [ADDR_W-1:0]         paddr,
    output logic                      pwrite,
    output logic [DATA_W-1:0]         pwdata,
    output logic [DATA_W/8-1:0]       pstrb,
    input  logic [NUM_SLV*DATA_W-1:0] prdata,
    input  logic [NUM_SLV-1:0]        pready,
    input  logic [NUM_SLV-1:0]        pslverr
);

    localparam int SEL_W  = sel_width(NUM_SLV);
    localparam int STRB_W = DATA_W / 8;

    state_e              state_q;
    logic [NUM_SLV-1:0]  psel_q;
    logic                penable_q;
    logic [ADDR_W-1:0]   paddr_q;
    logic                pwrite_q;
    logic [DATA_W-1:0]   pwdata_q;
    logic [STRB_W-1:0]   pstrb_q;
    logic [SEL_W-1:0]    idx_q;
    logic                rsp_valid_q;
    logic                rsp_write_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic                rsp_err_q;
    logic                err_pend_q;
    logic                err_write_q;

`ifdef APB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    logic [TMO_W-1:0]    tmo_q;
`endif

    logic [NUM_SLV-1:0]  dec_sel;
    logic [SEL_W-1:0]    dec_idx;
    logic                dec_err;
    logic                rdy;
    logic                slv_err;
    logic [DATA_W-1:0]   slv_rdata;
    logic                enc_ok;
    logic                req_ok;
    logic                accept;

    apb_addr_decode #(
        .NUM_SLV (NUM_SLV),
        .SEL_W   (SEL_W)
    ) u_decode (
        .addr_hi_i (trf_addr[ADDR_W-1 -: SEL_W]),
        .sel_o     (dec_sel),
        .idx_o     (dec_idx),
        .dec_err_o (dec_err)
    );

    // Only the slave addressed by the current transfer is observed.
    always_comb begin
        rdy       = 1'b0;
        slv_err   = 1'b0;
        slv_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == SEL_W'(i)) begin
                rdy       = pready[i];
                slv_err   = pslverr[i];
                slv_rdata = prdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign enc_ok    = (trf_enc == TRF_WR) || (trf_enc == TRF_RD);
    assign req_ok    = enc_ok && !dec_err;
    assign trf_ready = !prst && ((state_q == IDLE) || ((state_q == ACCESS) && rdy));
    assign accept    = trf_valid && trf_ready;

    always_ff @(posedge pclk or posedge prst) begin
        if (prst) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
            idx_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            err_pend_q  <= 1'b0;
            err_write_q <= 1'b0;
`ifdef APB_TIMEOUT_EN
            tmo_q       <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;

            case (state_q)
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
`ifdef APB_TIMEOUT_EN
                    tmo_q     <= '0;
`endif
                end
                ACCESS: begin
                    if (rdy) begin
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= pwrite_q;
                        rsp_err_q   <= slv_err;
                        rsp_rdata_q <= (!pwrite_q && !slv_err) ? slv_rdata : '0;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
`ifdef APB_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= pwrite_q;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        state_q     <= IDLE;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                // A rejected request accepted alongside a completion owes its error one cycle later.
                ERR: begin
                    if (err_pend_q) begin
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= err_write_q;
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                        err_pend_q  <= 1'b0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: ;
            endcase

            if (accept) begin
                penable_q <= 1'b0;
                if (req_ok) begin
                    state_q  <= SETUP;
                    psel_q   <= dec_sel;
                    idx_q    <= dec_idx;
                    paddr_q  <= trf_addr;
                    pwrite_q <= (trf_enc == TRF_WR);
                    pwdata_q <= trf_wdata;
                    pstrb_q  <= (trf_enc == TRF_WR) ? trf_strb : '0;
                end else begin
                    state_q <= ERR;
                    psel_q  <= '0;
                    if (state_q == ACCESS) begin
                        err_pend_q  <= 1'b1;
                        err_write_q <= (trf_enc == TRF_WR);
                    end else begin
                        rsp_valid_q <= 1'b1;
                        rsp_write_q <= (trf_enc == TRF_WR);
                        rsp_err_q   <= 1'b1;
                        rsp_rdata_q <= '0;
                    end
                end
            end
        end
    end

    assign psel      = psel_q;
    assign penable   = penable_q;
    assign paddr     = paddr_q;
    assign pwrite    = pwrite_q;
    assign pwdata    = pwdata_q;
    assign pstrb     = pstrb_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_mc.sv
// Scoreboard bench for apb_master_mc: stimulus pushes expected responses,
// a negedge monitor pops and compares them; a 3-slave instance covers decode errors.
module tb_apb_master_mc;
    import apb_pkg::*;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 8;
    localparam int NUM_SLV = 4;

    logic        pclk = 1'b0;
    logic        prst;
    logic        trf_valid, trf_valid3;
    logic        trf_ready, trf_ready3;
    logic [1:0]  trf_enc;
    logic [7:0]  trf_addr;
    logic [7:0]  trf_wdata;
    logic [0:0]  trf_strb;
    logic        rsp_valid, rsp_write, rsp_err;
    logic [7:0]  rsp_rdata;
    logic [3:0]  psel;
    logic        penable, pwrite;
    logic [7:0]  paddr, pwdata;
    logic [0:0]  pstrb;
    logic [31:0] prdata;
    logic [3:0]  pready, pslverr;

    logic        rsp_valid3, rsp_write3, rsp_err3, penable3, pwrite3;
    logic [7:0]  rsp_rdata3, paddr3, pwdata3;
    logic [2:0]  psel3;
    logic [0:0]  pstrb3;

    typedef struct packed {
        logic       write;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;

    rsp_t expQ[$];
    rsp_t monExp;
    int   checks = 0, passes = 0;
    int   rspPulses = 0, busCycles = 0, enableCycles = 0;
    int   edges;

    always #5 pclk = ~pclk;

    apb_master_mc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(NUM_SLV), .TIMEOUT(4)) dut (
        .pclk(pclk), .prst(prst),
        .trf_valid(trf_valid), .trf_ready(trf_ready), .trf_enc(trf_enc),
        .trf_addr(trf_addr), .trf_wdata(trf_wdata), .trf_strb(trf_strb),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .psel(psel), .penable(penable), .paddr(paddr), .pwrite(pwrite),
        .pwdata(pwdata), .pstrb(pstrb),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    apb_master_mc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SLV(3), .TIMEOUT(4)) dut3 (
        .pclk(pclk), .prst(prst),
        .trf_valid(trf_valid3), .trf_ready(trf_ready3), .trf_enc(trf_enc),
        .trf_addr(trf_addr), .trf_wdata(trf_wdata), .trf_strb(trf_strb),
        .rsp_valid(rsp_valid3), .rsp_write(rsp_write3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
        .psel(psel3), .penable(penable3), .paddr(paddr3), .pwrite(pwrite3),
        .pwdata(pwdata3), .pstrb(pstrb3),
        .prdata(prdata[23:0]), .pready(pready[2:0]), .pslverr(pslverr[2:0])
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    // Drive a request and hold it until accepted; queue its expected response.
    task automatic applyStimulus(input logic [1:0] enc, input logic [7:0] addr,
                                 input logic [7:0] wdata, input logic strb,
                                 input rsp_t exp, output int nEdges);
        logic acc;
        trf_valid = 1'b1;
        trf_enc   = enc;
        trf_addr  = addr;
        trf_wdata = wdata;
        trf_strb  = strb;
        acc       = 1'b0;
        nEdges    = 0;
        while (!acc && nEdges < 20) begin
            @(negedge pclk);
            acc = trf_ready;
            @(posedge pclk);
            #1;
            nEdges++;
        end
        if (acc) expQ.push_back(exp);
        else checkOutput("accept_timeout", {31'b0, trf_ready}, 32'd1);
    endtask

    always @(negedge pclk) begin
        if (psel != 4'b0) busCycles++;
        if (penable) enableCycles++;
        if (rsp_valid) begin
            rspPulses++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("rsp_write", {31'b0, rsp_write}, {31'b0, monExp.write});
                checkOutput("rsp_rdata", {24'b0, rsp_rdata}, {24'b0, monExp.rdata});
                checkOutput("rsp_err",   {31'b0, rsp_err},   {31'b0, monExp.err});
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int p0;
        prst = 1'b1; trf_valid = 1'b0; trf_valid3 = 1'b0;
        trf_enc = 2'b00; trf_addr = 8'h00; trf_wdata = 8'h00; trf_strb = 1'b0;
        prdata = 32'h5A33_2211; pready = 4'b0000; pslverr = 4'b0000;

        // Reset state
        #1;
        checkOutput("rst_psel",      {28'b0, psel},     32'd0);
        checkOutput("rst_penable",   {31'b0, penable},  32'd0);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("rst_trf_ready", {31'b0, trf_ready}, 32'd0);
        checkOutput("rst_paddr",     {24'b0, paddr},    32'd0);
        @(posedge pclk); #1 prst = 1'b0;
        @(negedge pclk);
        checkOutput("rel_trf_ready", {31'b0, trf_ready}, 32'd1);
        @(posedge pclk); #1;

        // 1: reset mid-ACCESS kills the transfer with no response
        applyStimulus(TRF_RD, 8'h00, 8'h00, 1'b0, '{write: 1'b0, rdata: 8'h11, err: 1'b0}, edges);
        trf_valid = 1'b0;
        @(posedge pclk); #1;
        checkOutput("t1_in_access", {31'b0, penable}, 32'd1);
        p0 = rspPulses;
        #2 prst = 1'b1;
        #1;
        checkOutput("t1_psel_async",    {28'b0, psel},    32'd0);
        checkOutput("t1_penable_async", {31'b0, penable}, 32'd0);
        expQ.delete();
        @(posedge pclk); #1 prst = 1'b0;
        @(negedge pclk);
        checkOutput("t1_trf_ready", {31'b0, trf_ready}, 32'd1);
        repeat (3) @(negedge pclk);
        checkOutput("t1_no_rsp", rspPulses - p0, 32'd0);
        @(posedge pclk); #1;

        // 2: zero-wait write to slave 1
        pready = 4'b0010;
        applyStimulus(TRF_WR, 8'h45, 8'hA5, 1'b1, '{write: 1'b1, rdata: 8'h00, err: 1'b0}, edges);
        trf_valid = 1'b0;
        @(negedge pclk);
        checkOutput("t2_setup_psel",    {28'b0, psel},    32'h2);
        checkOutput("t2_setup_penable", {31'b0, penable}, 32'd0);
        checkOutput("t2_paddr",         {24'b0, paddr},   32'h45);
        checkOutput("t2_pwdata",        {24'b0, pwdata},  32'hA5);
        checkOutput("t2_pwrite",        {31'b0, pwrite},  32'd1);
        checkOutput("t2_pstrb",         {31'b0, pstrb},   32'd1);
        @(negedge pclk);
        checkOutput("t2_access_psel",    {28'b0, psel},      32'h2);
        checkOutput("t2_access_penable", {31'b0, penable},   32'd1);
        checkOutput("t2_early_rsp",      {31'b0, rsp_valid}, 32'd0);
        @(negedge pclk);
        checkOutput("t2_rsp_latency", {31'b0, rsp_valid}, 32'd1);
        checkOutput("t2_idle_psel",   {28'b0, psel},      32'd0);
        @(posedge pclk); #1;

        // 3: read from slave 3 with three wait cycles
        pready = 4'b0000;
        enableCycles = 0;
        applyStimulus(TRF_RD, 8'hC3, 8'h00, 1'b1, '{write: 1'b0, rdata: 8'h5A, err: 1'b0}, edges);
        trf_valid = 1'b0;
        @(negedge pclk);
        checkOutput("t3_psel",  {28'b0, psel},  32'h8);
        checkOutput("t3_pstrb", {31'b0, pstrb}, 32'd0);
        repeat (4) @(posedge pclk);
        #1 pready = 4'b1000;
        repeat (3) @(negedge pclk);
        checkOutput("t3_access_cycles", enableCycles, 32'd4);
        @(posedge pclk); #1;

        // 4: back-to-back writes with trf_valid held
        pready = 4'b1111;
        busCycles = 0;
        p0 = rspPulses;
        applyStimulus(TRF_WR, 8'h10, 8'h01, 1'b1, '{write: 1'b1, rdata: 8'h00, err: 1'b0}, edges);
        checkOutput("t4_first_edges", edges, 32'd1);
        applyStimulus(TRF_WR, 8'h20, 8'h02, 1'b1, '{write: 1'b1, rdata: 8'h00, err: 1'b0}, edges);
        checkOutput("t4_second_edges", edges, 32'd2);
        trf_valid = 1'b0;
        repeat (4) @(negedge pclk);
        checkOutput("t4_bus_cycles", busCycles, 32'd4);
        checkOutput("t4_rsp_pulses", rspPulses - p0, 32'd2);
        @(posedge pclk); #1;

        // 5: illegal encoding, then decode error on the 3-slave instance
        applyStimulus(2'b11, 8'h45, 8'h00, 1'b0, '{write: 1'b0, rdata: 8'h00, err: 1'b1}, edges);
        trf_valid = 1'b0;
        @(negedge pclk);
        checkOutput("t5_err_rsp",     {31'b0, rsp_valid}, 32'd1);
        checkOutput("t5_err_psel",    {28'b0, psel},      32'd0);
        checkOutput("t5_err_penable", {31'b0, penable},   32'd0);
        @(negedge pclk);
        checkOutput("t5_back_idle", {31'b0, trf_ready}, 32'd1);
        @(posedge pclk); #1;
        trf_enc = TRF_WR; trf_addr = 8'hC0; trf_wdata = 8'h77; trf_strb = 1'b1;
        trf_valid3 = 1'b1;
        @(negedge pclk);
        checkOutput("t5_dec_ready", {31'b0, trf_ready3}, 32'd1);
        @(posedge pclk); #1 trf_valid3 = 1'b0;
        @(negedge pclk);
        checkOutput("t5_dec_rsp_valid", {31'b0, rsp_valid3}, 32'd1);
        checkOutput("t5_dec_rsp_err",   {31'b0, rsp_err3},   32'd1);
        checkOutput("t5_dec_rsp_rdata", {24'b0, rsp_rdata3}, 32'd0);
        checkOutput("t5_dec_psel",      {29'b0, psel3},      32'd0);
        @(negedge pclk);
        checkOutput("t5_dec_single_pulse", {31'b0, rsp_valid3}, 32'd0);
        @(posedge pclk); #1;

        // 6: slave error on read, then unselected slave errors are ignored
        pready = 4'b0100; pslverr = 4'b0100;
        applyStimulus(TRF_RD, 8'h80, 8'h00, 1'b0, '{write: 1'b0, rdata: 8'h00, err: 1'b1}, edges);
        trf_valid = 1'b0;
        repeat (4) @(negedge pclk);
        @(posedge pclk); #1;
        pslverr = 4'b1011;
        applyStimulus(TRF_RD, 8'h80, 8'h00, 1'b0, '{write: 1'b0, rdata: 8'h33, err: 1'b0}, edges);
        trf_valid = 1'b0;
        repeat (4) @(negedge pclk);
        @(posedge pclk); #1;
        pslverr = 4'b0000;

`ifdef APB_TIMEOUT_EN
        // Stuck slave is aborted after TIMEOUT ACCESS cycles
        pready = 4'b0000;
        enableCycles = 0;
        applyStimulus(TRF_RD, 8'h00, 8'h00, 1'b0, '{write: 1'b0, rdata: 8'h00, err: 1'b1}, edges);
        trf_valid = 1'b0;
        repeat (8) @(negedge pclk);
        checkOutput("tmo_access_cycles", enableCycles, 32'd4);
        checkOutput("tmo_psel_dropped", {28'b0, psel}, 32'd0);
        @(posedge pclk); #1;
`endif

        repeat (3) @(negedge pclk);
        checkOutput("queue_drained", expQ.size(), 32'd0);
        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
